// File: rtl/i2c_fifo_buffer_pkg.sv
// ============================================================================
// i2c_fifo_buffer_pkg : shared constants for the I2C TX/RX FIFO buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2c_fifo_buffer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 16;

    localparam int ST_TX_EMPTY     = 0;
    localparam int ST_TX_FULL      = 1;
    localparam int ST_RX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_TX_OVERFLOW  = 4;
    localparam int ST_RX_OVERFLOW  = 5;
    localparam int ST_RX_UNDERFLOW = 6;

    localparam logic [7:0] RESET_STATUS = 8'h05;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
// ============================================================================
// i2c_sync_fifo : first-word fall-through synchronous FIFO with error pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int                   PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);

    // A pop from a full FIFO frees the slot the simultaneous push needs.
    assign do_pop      = rd_en_i && !empty_o;
    assign do_push     = wr_en_i && (!full_o || do_pop);
    assign overflow_o  = wr_en_i && full_o && !rd_en_i;
    assign underflow_o = rd_en_i && empty_o;

    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/i2c_fifo_buffer.sv
// ============================================================================
// i2c_fifo_buffer : TX/RX FIFO pair plus sticky error status byte
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_fifo_buffer
    import i2c_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic [DATA_WIDTH-1:0] tx_wdata_i,
    input  logic                  tx_wr_en_i,
    input  logic                  tx_rd_en_i,
    output logic [DATA_WIDTH-1:0] tx_rdata_o,
    output logic [CNT_WIDTH-1:0]  tx_count_o,
    input  logic [DATA_WIDTH-1:0] rx_wdata_i,
    input  logic                  rx_wr_en_i,
    input  logic                  rx_rd_en_i,
    output logic [DATA_WIDTH-1:0] rx_rdata_o,
    output logic [CNT_WIDTH-1:0]  rx_count_o,
    input  logic                  clr_err_i,
    output logic [7:0]            status_o
);

    logic tx_empty, tx_full, tx_overflow, tx_underflow_unused;
    logic rx_empty, rx_full, rx_overflow, rx_underflow;
    logic tx_ovf_q, tx_ovf_d;
    logic rx_ovf_q, rx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    i2c_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_tx_fifo (
        .pclk_i      (pclk_i),
        .preset_ni   (preset_ni),
        .wdata_i     (tx_wdata_i),
        .wr_en_i     (tx_wr_en_i),
        .rd_en_i     (tx_rd_en_i),
        .rdata_o     (tx_rdata_o),
        .count_o     (tx_count_o),
        .empty_o     (tx_empty),
        .full_o      (tx_full),
        .overflow_o  (tx_overflow),
        .underflow_o (tx_underflow_unused)
    );

    i2c_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_rx_fifo (
        .pclk_i      (pclk_i),
        .preset_ni   (preset_ni),
        .wdata_i     (rx_wdata_i),
        .wr_en_i     (rx_wr_en_i),
        .rd_en_i     (rx_rd_en_i),
        .rdata_o     (rx_rdata_o),
        .count_o     (rx_count_o),
        .empty_o     (rx_empty),
        .full_o      (rx_full),
        .overflow_o  (rx_overflow),
        .underflow_o (rx_underflow)
    );

    // A fresh error in the same cycle as a clear must not be lost.
    always_comb begin
        tx_ovf_d = tx_overflow  || (tx_ovf_q && !clr_err_i);
        rx_ovf_d = rx_overflow  || (rx_ovf_q && !clr_err_i);
        rx_unf_d = rx_underflow || (rx_unf_q && !clr_err_i);
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    always_comb begin
        status_o                  = '0;
        status_o[ST_TX_EMPTY]     = tx_empty;
        status_o[ST_TX_FULL]      = tx_full;
        status_o[ST_RX_EMPTY]     = rx_empty;
        status_o[ST_RX_FULL]      = rx_full;
        status_o[ST_TX_OVERFLOW]  = tx_ovf_q;
        status_o[ST_RX_OVERFLOW]  = rx_ovf_q;
        status_o[ST_RX_UNDERFLOW] = rx_unf_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_fifo_buffer.sv
// ============================================================================
// tb_i2c_fifo_buffer : scoreboard bench for the I2C TX/RX FIFO buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_fifo_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          pclk_i    = 1'b0;
    logic          preset_ni = 1'b0;
    logic [DW-1:0] tx_wdata_i = '0;
    logic          tx_wr_en_i = 1'b0;
    logic          tx_rd_en_i = 1'b0;
    logic [DW-1:0] tx_rdata_o;
    logic [CW-1:0] tx_count_o;
    logic [DW-1:0] rx_wdata_i = '0;
    logic          rx_wr_en_i = 1'b0;
    logic          rx_rd_en_i = 1'b0;
    logic [DW-1:0] rx_rdata_o;
    logic [CW-1:0] rx_count_o;
    logic          clr_err_i = 1'b0;
    logic [7:0]    status_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] tx_sb[$];
    logic [DW-1:0] rx_sb[$];
    logic [DW-1:0] exp_b;

    i2c_fifo_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .pclk_i     (pclk_i),
        .preset_ni  (preset_ni),
        .tx_wdata_i (tx_wdata_i),
        .tx_wr_en_i (tx_wr_en_i),
        .tx_rd_en_i (tx_rd_en_i),
        .tx_rdata_o (tx_rdata_o),
        .tx_count_o (tx_count_o),
        .rx_wdata_i (rx_wdata_i),
        .rx_wr_en_i (rx_wr_en_i),
        .rx_rd_en_i (rx_rd_en_i),
        .rx_rdata_o (rx_rdata_o),
        .rx_count_o (rx_count_o),
        .clr_err_i  (clr_err_i),
        .status_o   (status_o)
    );

    always #5 pclk_i = ~pclk_i;

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic idle();
        tx_wr_en_i = 1'b0;
        tx_rd_en_i = 1'b0;
        rx_wr_en_i = 1'b0;
        rx_rd_en_i = 1'b0;
        clr_err_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        preset_ni = 1'b0;
        tick();
        vectors++; if (status_o !== 8'h05) begin miscompares++; $display("FAIL reset_status got %h expected 05", status_o); end
        preset_ni = 1'b1;
        tick();
        vectors++; if (status_o !== 8'h05) begin miscompares++; $display("FAIL idle_status got %h expected 05", status_o); end
        vectors++; if (tx_count_o !== 5'd0 || rx_count_o !== 5'd0) begin miscompares++; $display("FAIL idle_counts got %0d/%0d expected 0/0", tx_count_o, rx_count_o); end
        vectors++; if (tx_rdata_o !== 8'h00 || rx_rdata_o !== 8'h00) begin miscompares++; $display("FAIL idle_rdata got %h/%h expected 00/00", tx_rdata_o, rx_rdata_o); end
    endtask

    task automatic test_tx_fill();
        for (int i = 0; i < DEPTH; i++) begin
            tx_wdata_i = 8'h10 + 8'(i);
            tx_wr_en_i = 1'b1;
            tx_sb.push_back(tx_wdata_i);
            tick();
        end
        tx_wr_en_i = 1'b0;
        vectors++; if (tx_count_o !== 5'd16) begin miscompares++; $display("FAIL tx_full_count got %0d expected 16", tx_count_o); end
        vectors++; if (status_o !== 8'h06) begin miscompares++; $display("FAIL tx_full_status got %h expected 06", status_o); end
        tx_wdata_i = 8'hFF;
        tx_wr_en_i = 1'b1;
        tick();
        tx_wr_en_i = 1'b0;
        vectors++; if (status_o !== 8'h16) begin miscompares++; $display("FAIL tx_overflow_status got %h expected 16", status_o); end
        vectors++; if (tx_count_o !== 5'd16) begin miscompares++; $display("FAIL tx_overflow_count got %0d expected 16", tx_count_o); end
        while (tx_sb.size() > 0) begin
            exp_b = tx_sb.pop_front();
            vectors++; if (tx_rdata_o !== exp_b) begin miscompares++; $display("FAIL tx_pop_data got %h expected %h", tx_rdata_o, exp_b); end
            tx_rd_en_i = 1'b1;
            tick();
        end
        tx_rd_en_i = 1'b0;
        vectors++; if (tx_count_o !== 5'd0 || tx_rdata_o !== 8'h00) begin miscompares++; $display("FAIL tx_drained got %0d/%h expected 0/00", tx_count_o, tx_rdata_o); end
        tx_rd_en_i = 1'b1;
        tick();
        tx_rd_en_i = 1'b0;
        vectors++; if (status_o !== 8'h15) begin miscompares++; $display("FAIL tx_silent_underflow got %h expected 15", status_o); end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        vectors++; if (status_o !== 8'h05) begin miscompares++; $display("FAIL tx_clear got %h expected 05", status_o); end
    endtask

    task automatic test_rx_wrap();
        for (int i = 0; i < 10; i++) begin
            rx_wdata_i = 8'(i);
            rx_wr_en_i = 1'b1;
            rx_sb.push_back(rx_wdata_i);
            tick();
        end
        rx_wr_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_b = rx_sb.pop_front();
            vectors++; if (rx_rdata_o !== exp_b) begin miscompares++; $display("FAIL rx_first_pop got %h expected %h", rx_rdata_o, exp_b); end
            rx_rd_en_i = 1'b1;
            tick();
        end
        rx_rd_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_wdata_i = 8'hA0 + 8'(i);
            rx_wr_en_i = 1'b1;
            rx_sb.push_back(rx_wdata_i);
            tick();
        end
        rx_wr_en_i = 1'b0;
        vectors++; if (rx_count_o !== 5'd10) begin miscompares++; $display("FAIL rx_wrap_count got %0d expected 10", rx_count_o); end
        while (rx_sb.size() > 0) begin
            exp_b = rx_sb.pop_front();
            vectors++; if (rx_rdata_o !== exp_b) begin miscompares++; $display("FAIL rx_wrap_data got %h expected %h", rx_rdata_o, exp_b); end
            rx_rd_en_i = 1'b1;
            tick();
        end
        rx_rd_en_i = 1'b0;
        vectors++; if (status_o !== 8'h05) begin miscompares++; $display("FAIL rx_wrap_end_status got %h expected 05", status_o); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) begin
            rx_wdata_i = 8'h60 + 8'(i);
            rx_wr_en_i = 1'b1;
            rx_sb.push_back(rx_wdata_i);
            tick();
        end
        vectors++; if (status_o !== 8'h09) begin miscompares++; $display("FAIL rx_full_status got %h expected 09", status_o); end
        exp_b = rx_sb.pop_front();
        vectors++; if (rx_rdata_o !== exp_b) begin miscompares++; $display("FAIL rx_full_head got %h expected %h", rx_rdata_o, exp_b); end
        rx_wdata_i = 8'h55;
        rx_rd_en_i = 1'b1;
        rx_sb.push_back(8'h55);
        tick();
        idle();
        vectors++; if (rx_count_o !== 5'd16 || status_o !== 8'h09) begin miscompares++; $display("FAIL rx_full_pushpop got %0d/%h expected 16/09", rx_count_o, status_o); end
        while (rx_sb.size() > 0) begin
            exp_b = rx_sb.pop_front();
            vectors++; if (rx_rdata_o !== exp_b) begin miscompares++; $display("FAIL rx_full_drain got %h expected %h", rx_rdata_o, exp_b); end
            rx_rd_en_i = 1'b1;
            tick();
        end
        rx_rd_en_i = 1'b0;
        vectors++; if (exp_b !== 8'h55) begin miscompares++; $display("FAIL rx_last_entry got %h expected 55", exp_b); end
        rx_wdata_i = 8'h77;
        rx_wr_en_i = 1'b1;
        rx_rd_en_i = 1'b1;
        tick();
        idle();
        vectors++; if (rx_count_o !== 5'd1 || rx_rdata_o !== 8'h77) begin miscompares++; $display("FAIL rx_empty_pushpop got %0d/%h expected 1/77", rx_count_o, rx_rdata_o); end
        vectors++; if (status_o !== 8'h41) begin miscompares++; $display("FAIL rx_empty_pushpop_status got %h expected 41", status_o); end
        rx_rd_en_i = 1'b1;
        clr_err_i  = 1'b1;
        tick();
        idle();
        vectors++; if (status_o !== 8'h05) begin miscompares++; $display("FAIL rx_sim_cleanup got %h expected 05", status_o); end
    endtask

    task automatic test_underflow_clear();
        rx_rd_en_i = 1'b1;
        tick();
        rx_rd_en_i = 1'b0;
        vectors++; if (status_o[6] !== 1'b1) begin miscompares++; $display("FAIL rx_underflow_set got %b expected 1", status_o[6]); end
        tick();
        vectors++; if (status_o[6] !== 1'b1) begin miscompares++; $display("FAIL rx_underflow_sticky got %b expected 1", status_o[6]); end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        vectors++; if (status_o[6] !== 1'b0) begin miscompares++; $display("FAIL rx_underflow_clear got %b expected 0", status_o[6]); end
        clr_err_i  = 1'b1;
        rx_rd_en_i = 1'b1;
        tick();
        idle();
        vectors++; if (status_o[6] !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear got %b expected 1", status_o[6]); end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
    endtask

    task automatic test_fwft();
        vectors++; if (rx_rdata_o !== 8'h00) begin miscompares++; $display("FAIL fwft_pre got %h expected 00", rx_rdata_o); end
        rx_wdata_i = 8'h3C;
        rx_wr_en_i = 1'b1;
        tick();
        rx_wr_en_i = 1'b0;
        vectors++; if (rx_rdata_o !== 8'h3C) begin miscompares++; $display("FAIL fwft_push got %h expected 3c", rx_rdata_o); end
        rx_rd_en_i = 1'b1;
        tick();
        rx_rd_en_i = 1'b0;
        vectors++; if (rx_rdata_o !== 8'h00 || rx_count_o !== 5'd0) begin miscompares++; $display("FAIL fwft_pop got %h/%0d expected 00/0", rx_rdata_o, rx_count_o); end
    endtask

    task automatic test_back_to_back();
        // all four strobes together on independent FIFOs
        for (int i = 0; i < 4; i++) begin
            tx_wdata_i = 8'hC0 + 8'(i);
            rx_wdata_i = 8'hD0 + 8'(i);
            tx_wr_en_i = 1'b1;
            rx_wr_en_i = 1'b1;
            tx_rd_en_i = (i > 0);
            rx_rd_en_i = (i > 0);
            tick();
            vectors++; if (tx_rdata_o !== tx_wdata_i || rx_rdata_o !== rx_wdata_i) begin miscompares++; $display("FAIL b2b_heads got %h/%h expected %h/%h", tx_rdata_o, rx_rdata_o, tx_wdata_i, rx_wdata_i); end
        end
        idle();
        rx_rd_en_i = 1'b1;
        tick();
        tick();
        idle();
        vectors++; if (status_o !== 8'h44 || tx_count_o !== 5'd1) begin miscompares++; $display("FAIL b2b_status got %h/%0d expected 44/1", status_o, tx_count_o); end
        // asynchronous reset mid-operation, away from any clock edge
        #2;
        preset_ni = 1'b0;
        #1;
        vectors++; if (status_o !== 8'h05 || tx_count_o !== 5'd0 || tx_rdata_o !== 8'h00) begin miscompares++; $display("FAIL midfill_reset got %h/%0d/%h expected 05/0/00", status_o, tx_count_o, tx_rdata_o); end
        tick();
        preset_ni = 1'b1;
        tick();
        vectors++; if (rx_count_o !== 5'd0 || status_o !== 8'h05) begin miscompares++; $display("FAIL post_reset got %0d/%h expected 0/05", rx_count_o, status_o); end
    endtask

    initial begin
        test_reset();
        test_tx_fill();
        test_rx_wrap();
        test_simultaneous();
        test_underflow_clear();
        test_fwft();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
